// File: rtl/memory_access_if.sv
// memory_access_if: single-port data-memory request/ready bus
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/memory_access.sv
// memory_access: RV32I memory stage with EX/MEM and MEM/WB registers, store alignment, load extension and bus timeout
module memory_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_e,
  input  logic                   mem_read_e,
  input  logic                   mem_write_e,
  input  logic [2:0]             funct3_e,
  input  logic [31:0]            alu_out_e,
  input  logic [31:0]            store_data_e,
  input  logic [4:0]             rd_e,
  input  logic                   reg_write_e,
  output logic                   stall_m,
  memory_access_if.master        dmem,
  output logic [31:0]            result_w,
  output logic [4:0]             rd_w,
  output logic                   reg_write_w,
  output logic                   valid_w,
  output logic                   exception_w,
  output logic                   bus_error_w
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state, state_nx;
  logic        valid_m, mem_read_m, mem_write_m, reg_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_out_m, store_data_m;
  logic [4:0]  rd_m;
  logic [7:0]  wait_cnt, cur_cnt;
  logic        mem_op, fault, req, abort;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] load_data;
  // EX/MEM pipeline register, frozen while the memory stage stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m      <= 1'b0;
      mem_read_m   <= 1'b0;
      mem_write_m  <= 1'b0;
      reg_write_m  <= 1'b0;
      funct3_m     <= '0;
      alu_out_m    <= '0;
      store_data_m <= '0;
      rd_m         <= '0;
    end else if (!stall_m) begin
      valid_m      <= valid_e;
      mem_read_m   <= mem_read_e;
      mem_write_m  <= mem_write_e;
      reg_write_m  <= reg_write_e;
      funct3_m     <= funct3_e;
      alu_out_m    <= alu_out_e;
      store_data_m <= store_data_e;
      rd_m         <= rd_e;
    end
  end
  // Fault decode, request/abort/stall generation and next state; wait_cnt holds request cycles already spent
  always_comb begin
    mem_op   = valid_m & (mem_read_m | mem_write_m);
    fault    = mem_op & (((funct3_m[1:0] == 2'b01) & alu_out_m[0])
             | ((funct3_m == 3'b010) & (alu_out_m[1:0] != 2'b00))
             | (mem_write_m & (funct3_m[2] | (funct3_m[1:0] == 2'b11)))
             | (mem_read_m & ((funct3_m == 3'b011) | (funct3_m[2:1] == 2'b11))));
    req      = mem_op & ~fault;
    cur_cnt  = (state == WAIT) ? wait_cnt : 8'd0;
    abort    = req & ~dmem.ready & (cur_cnt == 8'(MAX_WAIT - 1));
    stall_m  = req & ~dmem.ready & ~abort;
    state_nx = stall_m ? WAIT : IDLE;
  end
  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= stall_m ? cur_cnt + 8'd1 : 8'd0;
    end
  end
  // Bus drive with store lane alignment; everything is zero when no request is presented
  always_comb begin
    dmem.req   = req;
    dmem.we    = req & mem_write_m;
    dmem.addr  = req ? {alu_out_m[31:2], 2'b00} : 32'd0;
    dmem.wdata = !req ? 32'd0 :
                 (funct3_m[1:0] == 2'b00) ? {4{store_data_m[7:0]}} :
                 (funct3_m[1:0] == 2'b01) ? {2{store_data_m[15:0]}} : store_data_m;
    dmem.be    = !req ? 4'b0000 :
                 (funct3_m[1:0] == 2'b00) ? 4'b0001 << alu_out_m[1:0] :
                 (funct3_m[1:0] == 2'b01) ? 4'b0011 << {alu_out_m[1], 1'b0} : 4'b1111;
  end
  // Load lane extraction and sign/zero extension
  always_comb begin
    lbyte     = alu_out_m[1] ? (alu_out_m[0] ? dmem.rdata[31:24] : dmem.rdata[23:16])
                             : (alu_out_m[0] ? dmem.rdata[15:8] : dmem.rdata[7:0]);
    lhalf     = alu_out_m[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    load_data = (funct3_m == 3'b000) ? {{24{lbyte[7]}}, lbyte} :
                (funct3_m == 3'b100) ? {24'd0, lbyte} :
                (funct3_m == 3'b001) ? {{16{lhalf[15]}}, lhalf} :
                (funct3_m == 3'b101) ? {16'd0, lhalf} : dmem.rdata;
  end
  // MEM/WB register; a stalled cycle retires a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_w    <= '0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
      valid_w     <= 1'b0;
      exception_w <= 1'b0;
      bus_error_w <= 1'b0;
    end else begin
      result_w    <= mem_read_m ? load_data : alu_out_m;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m & valid_m & ~fault & ~abort & ~stall_m;
      valid_w     <= valid_m & ~stall_m;
      exception_w <= fault;
      bus_error_w <= abort;
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed self-checking bench for memory_access
module tb_memory_access;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_e = 1'b0, mem_read_e = 1'b0, mem_write_e = 1'b0, reg_write_e = 1'b0;
  logic [2:0]  funct3_e = '0;
  logic [31:0] alu_out_e = '0, store_data_e = '0;
  logic [4:0]  rd_e = '0;
  logic        stall_m;
  logic [31:0] result_w;
  logic [4:0]  rd_w;
  logic        reg_write_w, valid_w, exception_w, bus_error_w;
  int          tests = 0, fails = 0;

  memory_access_if bus();

  memory_access #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .mem_read_e(mem_read_e),
    .mem_write_e(mem_write_e), .funct3_e(funct3_e), .alu_out_e(alu_out_e),
    .store_data_e(store_data_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .stall_m(stall_m), .dmem(bus.master), .result_w(result_w), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .valid_w(valid_w), .exception_w(exception_w),
    .bus_error_w(bus_error_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r, input logic rw);
    valid_e = v; mem_read_e = rd; mem_write_e = wr; funct3_e = f3;
    alu_out_e = a; store_data_e = sd; rd_e = r; reg_write_e = rw;
    #1;
  endtask

  task automatic nop();
    set_e(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  initial begin
    bus.ready = 1'b1;
    bus.rdata = '0;
    tick();
    tick();
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_be", 32'(bus.be), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_valid_w", 32'(valid_w), 32'd0);
    chk("rst_result_w", result_w, 32'd0);
    rst_n = 1'b1;
    // SW then LW at 0x104
    set_e(1'b1, 1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0, 1'b0);
    tick();
    set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 5'd5, 1'b1);
    chk("sw_req", 32'(bus.req), 32'd1);
    chk("sw_we", 32'(bus.we), 32'd1);
    chk("sw_be", 32'(bus.be), 32'hF);
    chk("sw_addr", bus.addr, 32'h104);
    chk("sw_wdata", bus.wdata, 32'hDEADBEEF);
    chk("sw_stall", 32'(stall_m), 32'd0);
    tick();
    bus.rdata = 32'hDEADBEEF;
    nop();
    chk("lw_we", 32'(bus.we), 32'd0);
    chk("lw_stall", 32'(stall_m), 32'd0);
    tick();
    chk("lw_result", result_w, 32'hDEADBEEF);
    chk("lw_rd", 32'(rd_w), 32'd5);
    chk("lw_regw", 32'(reg_write_w), 32'd1);
    chk("lw_valid", 32'(valid_w), 32'd1);
    // LB / LBU at 0x103, LHU at 0x102
    bus.rdata = 32'h80FFFF7F;
    set_e(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd1, 1'b1);
    tick();
    set_e(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 5'd2, 1'b1);
    tick();
    chk("lb_result", result_w, 32'hFFFFFF80);
    set_e(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 5'd3, 1'b1);
    tick();
    chk("lbu_result", result_w, 32'h00000080);
    nop();
    tick();
    chk("lhu_result", result_w, 32'h000080FF);
    // SH at 0x102
    set_e(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 1'b0);
    tick();
    nop();
    chk("sh_be", 32'(bus.be), 32'hC);
    chk("sh_wdata", bus.wdata, 32'hABCDABCD);
    chk("sh_addr", bus.addr, 32'h100);
    tick();
    // LW with Ready low for 3 cycles, ALU op waiting behind it
    set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 5'd7, 1'b1);
    tick();
    bus.ready = 1'b0;
    set_e(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'd0, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("wait_stall", 32'(stall_m), 32'd1);
      chk("wait_req", 32'(bus.req), 32'd1);
      chk("wait_addr", bus.addr, 32'h200);
      tick();
      chk("wait_bubble_valid", 32'(valid_w), 32'd0);
      chk("wait_bubble_regw", 32'(reg_write_w), 32'd0);
    end
    bus.ready = 1'b1;
    bus.rdata = 32'h11223344;
    #1;
    chk("wait_done_stall", 32'(stall_m), 32'd0);
    tick();
    nop();
    chk("wait_result", result_w, 32'h11223344);
    chk("wait_rd", 32'(rd_w), 32'd7);
    chk("wait_regw", 32'(reg_write_w), 32'd1);
    chk("wait_valid", 32'(valid_w), 32'd1);
    chk("alu_no_req", 32'(bus.req), 32'd0);
    tick();
    chk("alu_result", result_w, 32'h55);
    chk("alu_rd", 32'(rd_w), 32'd9);
    chk("alu_valid", 32'(valid_w), 32'd1);
    // Misaligned LW at 0x101
    set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd4, 1'b1);
    tick();
    nop();
    chk("mis_req", 32'(bus.req), 32'd0);
    tick();
    chk("mis_exc", 32'(exception_w), 32'd1);
    chk("mis_regw", 32'(reg_write_w), 32'd0);
    // Ready never asserted: abort in request cycle 4
    bus.ready = 1'b0;
    set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd3, 1'b1);
    tick();
    nop();
    chk("exc_clear", 32'(exception_w), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("to_stall", 32'(stall_m), 32'd1);
      tick();
    end
    chk("abort_req", 32'(bus.req), 32'd1);
    chk("abort_stall", 32'(stall_m), 32'd0);
    tick();
    chk("abort_buserr", 32'(bus_error_w), 32'd1);
    chk("abort_regw", 32'(reg_write_w), 32'd0);
    chk("abort_req_drop", 32'(bus.req), 32'd0);
    bus.ready = 1'b1;
    set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h304, 32'd0, 5'd6, 1'b1);
    tick();
    nop();
    chk("buserr_clear", 32'(bus_error_w), 32'd0);
    chk("idle_again_stall", 32'(stall_m), 32'd0);
    tick();
    chk("idle_again_valid", 32'(valid_w), 32'd1);
    // Reset during WAIT drops Req immediately
    bus.ready = 1'b0;
    set_e(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd8, 1'b1);
    tick();
    nop();
    tick();
    chk("pre_rst_req", 32'(bus.req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_req", 32'(bus.req), 32'd0);
    chk("rst_wait_stall", 32'(stall_m), 32'd0);
    chk("rst_wait_valid_w", 32'(valid_w), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.ready = 1'b1;
    tick();
    chk("post_rst_req", 32'(bus.req), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the RV32i pipeline, directly downstream of execute. Holds the EX/MEM pipeline register and drives a single-port data-memory request/ready bus. For stores it aligns data and byte enables; for loads it extracts and sign/zero-extends. It stalls the upstream pipeline while memory is busy, then presents the result to writeback through the MEM/WB register.

## Interface
- MAX_WAIT, 15: maximum cycles spent in WAIT before the access is aborted with a bus error (1..255).

- CLK  in  1  pipeline clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Valid_E  in  1  execute-stage instruction is valid.
- Mem_Read_E, Mem_Write_E  in  1 each  load / store instruction (never both).
- Funct3_E  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALU_Out_E  in  32  effective address, or ALU result for non-memory instructions.
- Store_Data_E  in  32  rs2 data for stores.
- Rd_E  in  5  destination register.
- Reg_Write_E  in  1  instruction writes rd.
- Stall_M  out  1  hold execute and earlier stages; EX/MEM register frozen.
- DMEM_Req  out  1  memory request valid.
- DMEM_We  out  1  1 = write.
- DMEM_Addr  out  32  word address {addr[31:2],2'b00}.
- DMEM_Wdata  out  32  store data replicated into lanes.
- DMEM_Be  out  4  byte enables.
- DMEM_Ready  in  1  memory accepts/completes the request this cycle.
- DMEM_Rdata  in  32  read word; valid when DMEM_Ready=1.
- Result_W  out  32  load data or ALU result.
- Rd_W  out  5  destination register.
- Reg_Write_W  out  1  write enable for writeback.
- Valid_W  out  1  retiring instruction is valid.
- Exception_W  out  1  misaligned or illegal access.
- Bus_Error_W  out  1  access timed out.

## Operation
- EX/MEM register holds the fields of each *_E input. It loads the *_E values every cycle Stall_M=0, and holds while Stall_M=1.
- Mem_Op_M = Valid_M & (Mem_Read_M | Mem_Write_M).
- Fault_M is set by any of:
  - H/HU at addr[0]=1;
  - W at addr[1:0]≠0;
  - store with Funct3 ∉ {000,001,010};
  - load with Funct3 ∈ {011,110,111}.
- A faulting access issues no request.
- FSM:
  - IDLE: DMEM_Req = Mem_Op_M & ~Fault_M, driven combinationally.
    - If DMEM_Req & DMEM_Ready, the access completes this cycle.
    - If DMEM_Req & ~DMEM_Ready, go to WAIT and clear Wait_Cnt.
  - WAIT: DMEM_Req=1, with address, data and Be stable (frozen register). Wait_Cnt increments each cycle.
    - DMEM_Ready returns the FSM to IDLE with completion.
    - Wait_Cnt==MAX_WAIT-1 without DMEM_Ready aborts to IDLE with Bus_Error.
- Stall_M = DMEM_Req & ~DMEM_Ready & ~abort.
- Store lanes:
  - SB: Wdata={4{d[7:0]}}, Be=0001<<addr[1:0].
  - SH: Wdata={2{d[15:0]}}, Be=0011<<{addr[1],0}.
  - SW: Be=1111.
- Load extraction from DMEM_Rdata, byte selected by addr[1:0], half by addr[1]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- MEM/WB register updates every cycle with Valid_W ← Valid_M & ~Stall_M.
  - While Stall_M=1 a bubble enters W (Valid_W=0, Reg_Write_W=0).
  - Result_W ← load data if Mem_Read_M, else ALU_Out_M.
  - Reg_Write_W ← Reg_Write_M & Valid_M & ~Fault_M & ~abort.
  - Exception_W ← Valid_M & Fault_M.
  - Bus_Error_W ← abort.
- Non-memory instructions pass through in one cycle with no request.

## Timing
- Reset (RST_N=0, asynchronous) forces all of the following to 0:
  - every register, FSM=IDLE, Wait_Cnt=0;
  - Stall_M, DMEM_Req, DMEM_We, DMEM_Addr, DMEM_Wdata, DMEM_Be;
  - Result_W, Rd_W, Reg_Write_W, Valid_W, Exception_W, Bus_Error_W.
- Reset asserted mid-WAIT drops DMEM_Req immediately and abandons the access.
- Latency:
  - E→M is 1 cycle.
  - M→W is 1 cycle when DMEM_Ready is high in the request cycle.
  - Each low-Ready cycle adds exactly 1 stall cycle.
- DMEM_Req, once asserted, stays high with unchanged Addr, We, Wdata and Be until the Ready or abort cycle.
- At most one outstanding request at a time.
- Back-to-back accesses may request in consecutive cycles; no idle cycle is required.
- Abort occurs in the MAX_WAIT-th cycle of the request. Stall_M is 0 in that cycle.

## Test plan
- Store then load at 0x104 (SW 0xDEADBEEF, then LW), Ready always 1:
  - DMEM_Be=1111, no Stall_M;
  - Result_W=0xDEADBEEF two cycles after LW enters E.
- LB at 0x103 with Rdata=0x80FF_FF7F:
  - Result_W=0xFFFFFF80.
  - LBU at the same address gives 0x00000080.
  - LHU at 0x102 gives 0x000080FF.
- SH at 0x102, data 0x1234ABCD:
  - DMEM_Be=1100, Wdata=0xABCDABCD, DMEM_Addr=0x100.
- LW with Ready held low for 3 cycles:
  - Stall_M=1 for exactly 3 cycles with Addr and Req stable;
  - 3 bubbles at W, then one valid retire.
- LW at 0x101:
  - no DMEM_Req;
  - Exception_W=1 and Reg_Write_W=0 next cycle.
- Ready never asserted, MAX_WAIT=4:
  - abort in request cycle 4;
  - Bus_Error_W=1 and Reg_Write_W=0, then FSM returns to IDLE.
  - Asserting RST_N low during WAIT drops Req in the same cycle.
